// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial, LSB-first unsigned subtractor computing idata1 - idata2 over WL
// clock cycles. A start/busy/done handshake launches one operation at a time.
// The result is WL+1 bits of two's complement, so it is always exact: the top
// bit is the final borrow.
//
// Optional build macro:
//   SERIAL_SUB_SATURATE_EN - when defined, a negative difference is clamped to
//                            zero (oBORROW still reports the borrow).
//
// Ports:
//   iCLK     in   1     rising-edge clock
//   iRST     in   1     asynchronous reset, active-high
//   iSTART   in   1     start request, only looked at while idle
//   idata1   in   WL    minuend (unsigned), captured on acceptance
//   idata2   in   WL    subtrahend (unsigned), captured on acceptance
//   oBUSY    out  1     high while the bit loop is running
//   oDONE    out  1     one-cycle pulse when odata/oBORROW update
//   oBORROW  out  1     final borrow, 1 when idata1 < idata2
//   odata    out  WL+1  two's complement difference, held between operations
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WL = 4
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iSTART,
  input  logic [WL-1:0] idata1,
  input  logic [WL-1:0] idata2,
  output logic          oBUSY,
  output logic          oDONE,
  output logic          oBORROW,
  output logic [WL:0]   odata
);

  localparam int CW = $clog2(WL);
  localparam logic [CW-1:0] LAST_CNT = CW'(WL - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [WL-1:0] a_q, a_d;
  logic [WL-1:0] b_q, b_d;
  // Only WL-1 earlier difference bits are ever needed: on the final edge the
  // current bit and the borrow are taken straight from the combinational path,
  // so the bit that would drop out of a full WL-bit register is never used.
  logic [WL-2:0] r_q, r_d;
  logic          br_q, br_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          borrow_q, borrow_d;
  logic [WL:0]   odata_q, odata_d;

  logic          diff_bit;
  logic          br_next;
  logic [WL-1:0] r_shift;

  // One full-subtractor cell working on the current LSBs of the operand
  // shift registers and the stored borrow.
  always_comb begin
    diff_bit = a_q[0] ^ b_q[0] ^ br_q;
    br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    r_shift  = {diff_bit, r_q};
  end

  // Next-state and datapath control. Everything holds by default; oDONE is a
  // pulse so it defaults low every cycle.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    borrow_d = borrow_q;
    odata_d  = odata_q;

    case (state_q)
      IDLE: begin
        if (iSTART) begin
          a_d     = idata1;
          b_d     = idata2;
          r_d     = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        r_d   = r_shift[WL-1:1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          borrow_d = br_next;
`ifdef SERIAL_SUB_SATURATE_EN
          // Unsigned saturation: any borrow means the true result is below 0.
          odata_d  = br_next ? '0 : {br_next, diff_bit, r_q};
`else
          odata_d  = {br_next, diff_bit, r_q};
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything at once so an
  // in-flight operation is abandoned without a done pulse.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
      odata_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      borrow_q <= borrow_d;
      odata_q  <= odata_d;
    end
  end

  assign oBUSY   = (state_q == SHIFT);
  assign oDONE   = done_q;
  assign oBORROW = borrow_q;
  assign odata   = odata_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor (WL = 4). A behavioural model
// tracks what every output must be from the handshake rules and plain integer
// subtraction; a compare process checks the DUT against it on every falling
// edge. Directed operations additionally check odata/oBORROW against
// hand-computed literals, and a shuffled sweep covers all 256 operand pairs.
// Honours SERIAL_SUB_SATURATE_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int WL = 4;
`ifdef SERIAL_SUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          iCLK   = 1'b0;
  logic          iRST   = 1'b1;
  logic          iSTART = 1'b0;
  logic [WL-1:0] idata1 = '0;
  logic [WL-1:0] idata2 = '0;
  logic          oBUSY;
  logic          oDONE;
  logic          oBORROW;
  logic [WL:0]   odata;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state.
  bit            mBusy   = 1'b0;
  int            mLeft   = 0;
  int            mA      = 0;
  int            mB      = 0;
  bit            mDone   = 1'b0;
  bit            mBorrow = 1'b0;
  logic [WL:0]   mOdata  = '0;

  serial_subtractor #(.WL(WL)) dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iSTART  (iSTART),
    .idata1  (idata1),
    .idata2  (idata2),
    .oBUSY   (oBUSY),
    .oDONE   (oDONE),
    .oBORROW (oBORROW),
    .odata   (odata)
  );

  // 10-unit clock; rising edges at 5, 15, 25, ...
  always #5 iCLK = ~iCLK;

  // Reference difference as plain integer arithmetic, wrapped to WL+1 bits,
  // with the optional clamp at zero.
  function automatic logic [WL:0] refResult(input int a, input int b);
    int          diff;
    logic [31:0] wide;
    diff = a - b;
    if (SAT && diff < 0) diff = 0;
    wide = diff;
    return wide[WL:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted request keeps the unit busy for WL edges, then the
  // result appears together with a one-cycle done. Reset wipes everything.
  always @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      mBusy   = 1'b0;
      mLeft   = 0;
      mDone   = 1'b0;
      mBorrow = 1'b0;
      mOdata  = '0;
    end else begin
      mDone = 1'b0;
      if (mBusy) begin
        mLeft--;
        if (mLeft == 0) begin
          mBusy   = 1'b0;
          mDone   = 1'b1;
          mBorrow = (mA < mB);
          mOdata  = refResult(mA, mB);
        end
      end else if (iSTART) begin
        mBusy = 1'b1;
        mLeft = WL;
        mA    = int'(idata1);
        mB    = int'(idata2);
      end
    end
  end

  // Every falling edge the DUT outputs must equal the model.
  always @(negedge iCLK) begin
    check("busy",   {31'd0, oBUSY},   {31'd0, mBusy});
    check("done",   {31'd0, oDONE},   {31'd0, mDone});
    check("borrow", {31'd0, oBORROW}, {31'd0, mBorrow});
    check("odata",  32'(odata),       32'(mOdata));
  end

  task automatic checkOutput(input string name, input logic [WL:0] expData, input logic expBorrow);
    check(name, 32'(odata), 32'(expData));
    check(name, {31'd0, oBORROW}, {31'd0, expBorrow});
  endtask

  // Raise iSTART for exactly one accepting edge; returns 2 units after it.
  task automatic applyStimulus(input int a, input int b);
    @(posedge iCLK);
    #2;
    iSTART = 1'b1;
    idata1 = WL'(a);
    idata2 = WL'(b);
    @(posedge iCLK);
    #2;
    iSTART = 1'b0;
  endtask

  // Bounded wait for oDONE on falling edges; cycles = index of the falling
  // edge it was seen on, -1 on timeout (counted as a failure).
  task automatic waitDone(output int cycles);
    cycles = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge iCLK);
      if (oDONE) begin
        cycles = i;
        break;
      end
    end
    if (cycles < 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL timeout: got no oDONE expected oDONE within 20 cycles");
    end
  endtask

  task automatic runAndCheck(input string name, input int a, input int b,
                             input logic [WL:0] expData, input logic expBorrow);
    int cyc;
    applyStimulus(a, b);
    waitDone(cyc);
    check("latency", 32'(cyc), 32'(WL));
    checkOutput(name, expData, expBorrow);
  endtask

  // Hard stop in case something wedges the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish expected finish by t=1000000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by the exhaustive shuffled sweep.
  initial begin
    int cyc;
    int doneSeen;
    int order[256];

    $display("[TB] start, saturate=%0d", SAT);

    // Reset values while reset is held.
    repeat (2) @(negedge iCLK);
    checkOutput("reset", 5'b00000, 1'b0);
    check("resetBusy", {31'd0, oBUSY}, 32'd0);
    check("resetDone", {31'd0, oDONE}, 32'd0);
    @(posedge iCLK);
    #2;
    iRST = 1'b0;

    // Basic operations with hand-computed results.
    runAndCheck("9-3",  9,  3, 5'b00110, 1'b0);
    runAndCheck("3-9",  3,  9, SAT ? 5'b00000 : 5'b11010, 1'b1);
    runAndCheck("15-0", 15, 0, 5'b01111, 1'b0);
    runAndCheck("0-15", 0, 15, SAT ? 5'b00000 : 5'b10001, 1'b1);
    runAndCheck("7-7",  7,  7, 5'b00000, 1'b0);

    // Requests while busy are ignored and operands may change after capture.
    applyStimulus(9, 3);
    idata1 = 4'd1;
    idata2 = 4'd2;
    @(posedge iCLK);
    #2;
    iSTART = 1'b1;
    @(posedge iCLK);
    @(posedge iCLK);
    #2;
    iSTART = 1'b0;
    waitDone(cyc);
    check("busyLatency", 32'(cyc), 32'd1);
    checkOutput("busyIgnore", 5'b00110, 1'b0);

    // Back-to-back: start requested in the done cycle is accepted.
    iSTART = 1'b1;
    idata1 = 4'd1;
    idata2 = 4'd2;
    @(posedge iCLK);
    #2;
    iSTART = 1'b0;
    waitDone(cyc);
    check("b2bLatency", 32'(cyc), 32'(WL));
    checkOutput("backToBack", SAT ? 5'b00000 : 5'b11111, 1'b1);

    // Reset mid-operation: outputs clear without a clock, no done follows.
    applyStimulus(12, 5);
    @(posedge iCLK);
    @(posedge iCLK);
    #2;
    iRST = 1'b1;
    #1;
    checkOutput("rstMid", 5'b00000, 1'b0);
    check("rstMidBusy", {31'd0, oBUSY}, 32'd0);
    check("rstMidDone", {31'd0, oDONE}, 32'd0);
    @(posedge iCLK);
    #2;
    iRST = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < WL + 2; i++) begin
      @(negedge iCLK);
      if (oDONE) doneSeen++;
    end
    check("noDoneAfterRst", 32'(doneSeen), 32'd0);
    runAndCheck("12-5", 12, 5, 5'b00111, 1'b0);

    // Every operand pair, visited in a shuffled order.
    for (int k = 0; k < 256; k++) order[k] = k;
    for (int k = 255; k > 0; k--) begin
      int j;
      int t;
      j = int'($urandom_range(k, 0));
      t = order[k];
      order[k] = order[j];
      order[j] = t;
    end
    for (int k = 0; k < 256; k++) begin
      int a;
      int b;
      a = order[k] / 16;
      b = order[k] % 16;
      runAndCheck("sweep", a, b, refResult(a, b), a < b);
    end

    repeat (2) @(negedge iCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
